// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter that time-shares one combinational ALU and returns a tagged, stallable response.
// Optional ALU_ARB_RR_EN selects round-robin tie breaking; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int OP_W   = 4,
  parameter int MAX_OP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             id_q, id_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_err_q, res_err_d;
  logic             grant0_s, grant1_s;
  logic             op_illegal_s;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  // Round-robin grant: on a tie the requester not granted last time wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant0_s = last_q;
      grant1_s = !last_q;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  // Last-grant pointer moves only on an accepted request.
  always_comb begin
    if (req0_ready) begin
      last_d = 1'b0;
    end else if (req1_ready) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset value lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority grant: requester 1 only when requester 0 is idle.
  always_comb begin
    grant0_s = req0_valid;
    grant1_s = req1_valid && !req0_valid;
  end
`endif

  assign req0_ready   = (state_q == IDLE) && grant0_s;
  assign req1_ready   = (state_q == IDLE) && grant1_s;
  assign op_illegal_s = (op_q > OP_W'(MAX_OP));

  // Next-state and datapath capture for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_err_d   = res_err_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          a_d     = req0_a;
          b_d     = req0_b;
          op_d    = req0_op;
          id_d    = 1'b0;
          state_d = EXEC;
        end else if (req1_ready) begin
          a_d     = req1_a;
          b_d     = req1_b;
          op_d    = req1_op;
          id_d    = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // Illegal op codes never expose whatever the ALU produced.
        if (op_illegal_s) begin
          res_data_d = '0;
          res_zero_d = 1'b1;
        end else begin
          res_data_d = alu_result;
          res_zero_d = alu_zero;
        end
        res_err_d   = op_illegal_s;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // All FSM state, operand registers and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_err_q   <= res_err_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = op_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached.
// Tie-break expectations follow ALU_ARB_RR_EN when it is defined for the build.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        res_valid, res_ready, res_id, res_zero, res_err;
  logic [31:0] res_data;

  int checks;
  int failures;

  alu_share_arbiter #(.WIDTH(32), .OP_W(4), .MAX_OP(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .res_err    (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; unknown codes return a non-zero value so masking is visible.
  always_comb begin
    case (alu_ctrl)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a ^ alu_b;
      4'd5:    alu_result = alu_a << alu_b[4:0];
      4'd6:    alu_result = alu_a >> alu_b[4:0];
      4'd7:    alu_result = {31'd0, (alu_a < alu_b)};
      4'd8:    alu_result = alu_b;
      default: alu_result = alu_a ^ alu_b ^ 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Single operation from one requester with the consumer always ready; entered in IDLE, 1 after an edge.
  task automatic do_op(input logic rid, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] exp_data, input logic exp_zero, input logic exp_err);
    res_ready = 1'b1;
    if (rid) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    check_eq("op_ready", rid ? req1_ready : req0_ready, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("exec_ctrl", alu_ctrl, {28'd0, op});
    check_eq("exec_a", alu_a, a);
    check_eq("exec_b", alu_b, b);
    check_eq("exec_no_valid", res_valid, 32'd0);
    @(posedge clk); #1;
    check_eq("resp_valid", res_valid, 32'd1);
    check_eq("resp_data", res_data, exp_data);
    check_eq("resp_zero", res_zero, exp_zero);
    check_eq("resp_id", res_id, rid);
    check_eq("resp_err", res_err, exp_err);
    @(posedge clk); #1;
    check_eq("resp_done", res_valid, 32'd0);
  endtask

  initial begin
    logic [3:0] exp_ids;
    logic       r1_seen;
    logic       got;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", res_valid, 32'd0);
    check_eq("rst_id", res_id, 32'd0);
    check_eq("rst_data", res_data, 32'd0);
    check_eq("rst_zero", res_zero, 32'd0);
    check_eq("rst_err", res_err, 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_alu_ctrl", alu_ctrl, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain add, then a subtract whose result is zero.
    do_op(1'b0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0, 1'b0);
    do_op(1'b1, 32'd9, 32'd9, 4'd1, 32'd0, 1'b1, 1'b0);

    // Both requesters valid back to back.
    apply_reset();
`ifdef ALU_ARB_RR_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2;  req0_op = 4'd0;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_op = 4'd0;
    res_ready = 1'b1;
    r1_seen = 1'b0;
    #1;
    if (req1_ready) r1_seen = 1'b1;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(posedge clk); #1;
        if (req1_ready) r1_seen = 1'b1;
        if (res_valid) got = 1'b1;
      end
      check_eq("tie_got_resp", got, 32'd1);
      check_eq("tie_id", res_id, exp_ids[n]);
      check_eq("tie_data", res_data, exp_ids[n] ? 32'd30 : 32'd3);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
`ifdef ALU_ARB_RR_EN
    check_eq("tie_req1_ready_seen", r1_seen, 32'd1);
`else
    check_eq("tie_req1_ready_seen", r1_seen, 32'd0);
`endif
    @(posedge clk); #1;

    // Consumer stall with both requesters pending.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk); #1;
      if (res_valid) got = 1'b1;
    end
    check_eq("stall_got_resp", got, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_eq("stall_valid", res_valid, 32'd1);
      check_eq("stall_data", res_data, 32'd3);
      check_eq("stall_id", res_id, 32'd0);
      check_eq("stall_ready0", req0_ready, 32'd0);
      check_eq("stall_ready1", req1_ready, 32'd0);
    end
    req1_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("stall_release", res_valid, 32'd0);
    check_eq("stall_next_ready", req0_ready, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check_eq("stall_next_exec", alu_a, 32'd1);
    @(posedge clk); #1;
    check_eq("stall_next_valid", res_valid, 32'd1);
    check_eq("stall_next_data", res_data, 32'd3);
    @(posedge clk); #1;
    check_eq("stall_next_done", res_valid, 32'd0);

    // Illegal op code: result masked regardless of ALU output.
    do_op(1'b0, 32'd3, 32'd4, 4'b1010, 32'd0, 1'b1, 1'b1);

    // Reset asserted in the middle of EXEC.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'd0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check_eq("abort_pre_a", alu_a, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", res_valid, 32'd0);
    check_eq("abort_err", res_err, 32'd0);
    check_eq("abort_zero", res_zero, 32'd0);
    check_eq("abort_alu_a", alu_a, 32'd0);
    check_eq("abort_alu_b", alu_b, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_still_idle", res_valid, 32'd0);
    do_op(1'b0, 32'h0000_00F0, 32'h0000_000F, 4'd3, 32'h0000_00FF, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
